// File: rtl/scan_bridge_pkg.sv
// Shared definitions for the scan-to-memory bridge.
//   - default address / data widths
//   - timeout counter width
//   - bridge FSM state encoding
//   - saturating increment helper for the timeout counter
package scan_bridge_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RD_WAIT = 2'd2
  } bridge_state_e;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/scan_mem_bridge_sync_toggle.sv
// sync_toggle: brings a level-toggling request line from the scan domain
// into clk and turns every change of it into a one-cycle pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : toggle line from the other domain
//   tog        : one-cycle pulse per synchronized change of async_in
// All three flops reset to 0, so an input sitting at 0 out of reset
// never produces a pulse.
module sync_toggle (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tog
);

  logic sync1_r;
  logic sync2_r;
  logic edge_r;

  // Two-flop synchronizer followed by the edge (previous value) register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
    end
  end

  // High for exactly the one cycle in which sync2_r and edge_r disagree.
  assign tog = sync2_r ^ edge_r;

endmodule

// File: rtl/scan_mem_bridge.sv
// scan_mem_bridge: turns scan-loaded request registers plus a request
// toggle into a single valid/ready bus access, and holds the result
// (read data, done flag, sticky error) for scan capture.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   scan_id                      : request toggle, each edge = one request
//   req_wen/req_ren/req_addr/req_wdata : scan-loaded request fields
//   mem_valid/mem_wen/mem_addr/mem_wdata : bus request (held until mem_ready)
//   mem_ready                    : bus accepts the request
//   mem_rvalid/mem_rdata         : read return
//   resp_rdata/resp_ready/resp_err : captured result for scan
module scan_mem_bridge
  import scan_bridge_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_id,
  input  logic              req_wen,
  input  logic              req_ren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_ready,
  output logic              resp_err
);

  // The counter saturates at all-ones, so a larger limit could never be hit.
  localparam int CNT_MAX_C  = (1 << CNT_W) - 1;
  localparam int TO_CLAMP_C = (TIMEOUT > CNT_MAX_C) ? CNT_MAX_C :
                              ((TIMEOUT < 0) ? 0 : TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LIMIT_C = CNT_W'(TO_CLAMP_C);

  bridge_state_e     state_r;
  logic              tog_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              timeout_s;
  logic              mem_valid_r;
  logic              mem_wen_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic              resp_ready_r;
  logic              resp_err_r;

  sync_toggle u_sync_toggle (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (scan_id),
    .tog      (tog_s)
  );

  // Count after this cycle and whether that count hits the abort limit.
  always_comb begin
    cnt_next_s = sat_inc(cnt_r);
    timeout_s  = 1'b0;
    if (cnt_next_s >= TO_LIMIT_C) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Bridge FSM with all bus and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      mem_valid_r  <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      resp_rdata_r <= '0;
      resp_ready_r <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tog_s) begin
            mem_addr_r  <= req_addr;
            mem_wdata_r <= req_wdata;
            mem_wen_r   <= req_wen;
            cnt_r       <= '0;
            if (req_wen ^ req_ren) begin
              state_r      <= ST_REQ;
              mem_valid_r  <= 1'b1;
              resp_ready_r <= 1'b0;
              resp_err_r   <= 1'b0;
            end else begin
              // Ambiguous request: report done-with-error, no bus access.
              resp_ready_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          // A new request while busy is an overrun; the current one carries on.
          if (tog_s) begin
            resp_err_r <= 1'b1;
          end
          // Acceptance wins over a timeout landing in the same cycle.
          if (mem_ready) begin
            mem_valid_r <= 1'b0;
            if (mem_wen_r) begin
              state_r      <= ST_IDLE;
              resp_ready_r <= 1'b1;
            end else if (mem_rvalid) begin
              state_r      <= ST_IDLE;
              resp_rdata_r <= mem_rdata;
              resp_ready_r <= 1'b1;
            end else begin
              state_r <= ST_RD_WAIT;
              cnt_r   <= cnt_next_s;
            end
          end else if (timeout_s) begin
            state_r      <= ST_IDLE;
            mem_valid_r  <= 1'b0;
            resp_ready_r <= 1'b1;
            resp_err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end

        ST_RD_WAIT: begin
          if (tog_s) begin
            resp_err_r <= 1'b1;
          end
          if (mem_rvalid) begin
            state_r      <= ST_IDLE;
            resp_rdata_r <= mem_rdata;
            resp_ready_r <= 1'b1;
          end else if (timeout_s) begin
            state_r      <= ST_IDLE;
            resp_ready_r <= 1'b1;
            resp_err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle.
          state_r     <= ST_IDLE;
          mem_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid  = mem_valid_r;
  assign mem_wen    = mem_wen_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_ready = resp_ready_r;
  assign resp_err   = resp_err_r;

endmodule
